// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory slave: on-chip RAM with programmable wait states and a fixed
// read latency. Reads are pipelined, so a new read may be accepted every cycle.
module avalon_mem_responder #(
   parameter int DEPTH        = 1024,
   parameter int WAIT_STATES  = 1,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   output logic        slave_waitrequest,
   output logic [31:0] slave_readdata,
   output logic        slave_readdatavalid,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic        err_sticky,
   input  logic        err_clear
);
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   logic [31:0]                   mem_q [DEPTH];
   logic [3:0]                    ws_cnt_q, ws_cnt_d;
   logic [READ_LATENCY-1:0]       vld_pipe_q;
   logic [READ_LATENCY-1:0][31:0] dat_pipe_q;
   logic [31:0]                   rd_count_q, wr_count_q;
   logic                          err_q, err_d;
   logic                          cmd, accept, in_range, wr_acc, rd_acc, err_set;
   logic [AW-1:0]                 idx;
   logic [31:0]                   rd_word;
   logic                          unused_addr_lsb;

   assign unused_addr_lsb   = &{1'b0, slave_address[1:0]};
   assign cmd               = slave_read | slave_write;
   assign slave_waitrequest = cmd && (ws_cnt_q != WS);
   assign accept            = cmd && !slave_waitrequest;
   assign in_range          = {1'b0, slave_address} < LIMIT;
   assign idx               = slave_address[AW+1:2];
   // a write wins when both strobes are high; the read is dropped
   assign wr_acc            = accept && slave_write;
   assign rd_acc            = accept && slave_read && !slave_write;
   assign err_set           = accept && ((slave_read && slave_write) || !in_range);
   assign rd_word           = in_range ? mem_q[idx] : 32'hDEAD_BEEF;
   assign ws_cnt_d          = (!cmd || accept) ? 4'd0 : ws_cnt_q + 4'd1;

   always_comb begin
      err_d = err_q;
      if (err_clear) err_d = 1'b0;
      if (err_set)   err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_acc && in_range) mem_q[idx] <= slave_writedata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_cnt_q      <= '0;
         rd_count_q    <= '0;
         wr_count_q    <= '0;
         err_q         <= 1'b0;
         vld_pipe_q[0] <= 1'b0;
         dat_pipe_q[0] <= '0;
      end else begin
         ws_cnt_q      <= ws_cnt_d;
         err_q         <= err_d;
         vld_pipe_q[0] <= rd_acc;
         if (rd_acc) begin
            rd_count_q    <= rd_count_q + 32'd1;
            dat_pipe_q[0] <= rd_word;
         end
         if (wr_acc) wr_count_q <= wr_count_q + 32'd1;
      end
   end

   // data stages only move with a valid beat, so the last stage holds the last read
   for (genvar i = 1; i < READ_LATENCY; i++) begin : g_pipe
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_pipe_q[i] <= 1'b0;
            dat_pipe_q[i] <= '0;
         end else begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
         end
      end
   end

   assign slave_readdatavalid = vld_pipe_q[READ_LATENCY-1];
   assign slave_readdata      = dat_pipe_q[READ_LATENCY-1];
   assign rd_count            = rd_count_q;
   assign wr_count            = wr_count_q;
   assign err_sticky          = err_q;
endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: three instances with different
// wait-state/latency settings share one bus; sel routes the command strobes.
module tb_avalon_mem_responder;
   logic        clk = 0, rst_n = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        rd = 0, wr = 0, errclr = 0;
   int          sel = 0, cyc = 0, tests = 0, fails = 0;
   logic        waitreq [3], rdv [3], err [3];
   logic [31:0] rdd [3], rdc [3], wrc [3];
   logic [31:0] q_d [$];
   int          q_c [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avalon_mem_responder #(.DEPTH(1024), .WAIT_STATES(1), .READ_LATENCY(2)) u0 (
      .clk(clk), .rst_n(rst_n), .slave_address(addr), .slave_read(rd && sel == 0),
      .slave_write(wr && sel == 0), .slave_writedata(wdata), .slave_waitrequest(waitreq[0]),
      .slave_readdata(rdd[0]), .slave_readdatavalid(rdv[0]), .rd_count(rdc[0]),
      .wr_count(wrc[0]), .err_sticky(err[0]), .err_clear(errclr));
   avalon_mem_responder #(.DEPTH(64), .WAIT_STATES(0), .READ_LATENCY(3)) u1 (
      .clk(clk), .rst_n(rst_n), .slave_address(addr), .slave_read(rd && sel == 1),
      .slave_write(wr && sel == 1), .slave_writedata(wdata), .slave_waitrequest(waitreq[1]),
      .slave_readdata(rdd[1]), .slave_readdatavalid(rdv[1]), .rd_count(rdc[1]),
      .wr_count(wrc[1]), .err_sticky(err[1]), .err_clear(errclr));
   avalon_mem_responder #(.DEPTH(64), .WAIT_STATES(0), .READ_LATENCY(4)) u2 (
      .clk(clk), .rst_n(rst_n), .slave_address(addr), .slave_read(rd && sel == 2),
      .slave_write(wr && sel == 2), .slave_writedata(wdata), .slave_waitrequest(waitreq[2]),
      .slave_readdata(rdd[2]), .slave_readdatavalid(rdv[2]), .rd_count(rdc[2]),
      .wr_count(wrc[2]), .err_sticky(err[2]), .err_clear(errclr));

   always @(negedge clk) if (rdv[sel]) begin q_d.push_back(rdd[sel]); q_c.push_back(cyc); end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_xfer(input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d, output int waits);
      @(negedge clk);
      addr = a; wdata = d; rd = r; wr = w; waits = 0;
      #1;
      while (waitreq[sel] && waits < 50) begin @(negedge clk); #1; waits++; end
      if (waits >= 50) chk("wait_timeout", 1, 0);
      @(posedge clk); #1;
      rd = 0; wr = 0;
   endtask

   task automatic read_word(input logic [31:0] a, output logic [31:0] d, output int lat);
      int acc, n, w;
      q_d.delete(); q_c.delete();
      bus_xfer(0, 1, a, 0, w);
      acc = cyc; n = 0;
      while (q_d.size() == 0 && n < 20) begin @(negedge clk); #2; n++; end
      if (q_d.size() == 0) begin chk("rd_timeout", 1, 0); d = 0; lat = -1; end
      else begin d = q_d[0]; lat = q_c[0] - acc + 1; end
   endtask

   initial begin
      logic [31:0] d, rc0, wc0;
      int w, lat, acc0, bad;
      repeat (3) @(negedge clk);
      rst_n = 1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            if (waitreq[k] || rdv[k] || rdc[k] != 0 || wrc[k] != 0 || err[k] || rdd[k] != 0) bad++;
      end
      chk("idle_after_reset", bad, 0);

      // WS=1, LAT=2 single write then read
      bus_xfer(1, 0, 32'h10, 32'hCAFEF00D, w);
      chk("wr_waits", w, 1);
      q_d.delete(); q_c.delete();
      bus_xfer(0, 1, 32'h10, 0, w);
      chk("rd_waits", w, 1);
      acc0 = cyc;
      repeat (4) @(negedge clk);
      #2;
      chk("rd_pulses", q_d.size(), 1);
      if (q_d.size() > 0) begin
         chk("rd_data", q_d[0], 32'hCAFEF00D);
         chk("rd_lat", q_c[0] - acc0 + 1, 2);
      end
      chk("wr_count1", wrc[0], 1);
      chk("rd_count1", rdc[0], 1);
      chk("rdata_hold", rdd[0], 32'hCAFEF00D);
      chk("rdv_low_idle", rdv[0], 0);

      // copy 8 words 0x100 -> 0x200
      for (int i = 0; i < 8; i++) bus_xfer(1, 0, 32'h100 + 4 * i, 32'hA000 + i, w);
      rc0 = rdc[0]; wc0 = wrc[0];
      for (int i = 0; i < 8; i++) begin
         read_word(32'h100 + 4 * i, d, lat);
         bus_xfer(1, 0, 32'h200 + 4 * i, d, w);
      end
      chk("copy_rd_count", rdc[0] - rc0, 8);
      chk("copy_wr_count", wrc[0] - wc0, 8);
      chk("copy_err", err[0], 0);
      for (int i = 0; i < 8; i++) begin
         read_word(32'h200 + 4 * i, d, lat);
         chk($sformatf("copy_dst%0d", i), d, 32'hA000 + i);
      end

      // out-of-range read
      read_word(32'h1000, d, lat);
      chk("oor_data", d, 32'hDEADBEEF);
      chk("oor_lat", lat, 2);
      chk("oor_err", err[0], 1);
      @(negedge clk); errclr = 1; @(negedge clk); errclr = 0;
      chk("err_clear", err[0], 0);

      // out-of-range write is dropped; clear coinciding with new error keeps it set
      bus_xfer(1, 0, 32'h0, 32'h11, w);
      errclr = 1;
      bus_xfer(1, 0, 32'h1000, 32'h99, w);
      errclr = 0;
      chk("clr_vs_set", err[0], 1);
      read_word(32'h0, d, lat);
      chk("oor_wr_ignored", d, 32'h11);

      // read+write together: write done, read dropped
      rc0 = rdc[0]; wc0 = wrc[0];
      q_d.delete(); q_c.delete();
      bus_xfer(1, 1, 32'h20, 32'h55, w);
      repeat (6) @(negedge clk);
      #2;
      chk("rw_no_valid", q_d.size(), 0);
      chk("rw_rd_count", rdc[0], rc0);
      chk("rw_wr_count", wrc[0], wc0 + 1);
      chk("rw_err", err[0], 1);
      read_word(32'h20, d, lat);
      chk("rw_wr_data", d, 32'h55);

      // WS=0, LAT=3 back-to-back reads
      sel = 1;
      for (int i = 0; i < 4; i++) bus_xfer(1, 0, 4 * i, i + 1, w);
      chk("ws0_no_wait", w, 0);
      q_d.delete(); q_c.delete();
      acc0 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); addr = 4 * i; rd = 1;
         @(posedge clk); #1;
         if (i == 0) acc0 = cyc;
      end
      @(negedge clk); rd = 0;
      repeat (8) @(negedge clk);
      #2;
      chk("b2b_pulses", q_d.size(), 4);
      for (int i = 0; i < 4 && i < q_d.size(); i++) begin
         chk($sformatf("b2b_data%0d", i), q_d[i], i + 1);
         chk($sformatf("b2b_cyc%0d", i), q_c[i] - acc0, 2 + i);
      end

      // reset during an in-flight read (LAT=4)
      sel = 2;
      bus_xfer(1, 0, 32'h40, 32'h1234, w);
      q_d.delete(); q_c.delete();
      bus_xfer(0, 1, 32'h40, 0, w);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("rst_rdv_low", rdv[2], 0);
      chk("rst_rd_count", rdc[2], 0);
      @(negedge clk); @(negedge clk); rst_n = 1;
      repeat (10) @(negedge clk);
      #2;
      chk("rst_no_stale", q_d.size(), 0);
      read_word(32'h40, d, lat);
      chk("ram_kept", d, 32'h1234);
      chk("lat4", lat, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
